// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the BRAM controller response FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OK,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_bram_lane_decode.sv
// Maps transfer size and low address bits to a byte-lane mask and a legality flag.
module ahb_bram_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       legal
);

  always_comb begin
    mask  = '0;
    legal = 1'b0;
    case (hsize)
      SIZE_BYTE: begin
        legal = 1'b1;
        mask  = 4'b0001 << addr_lo;
      end
      SIZE_HALF: begin
        legal = ~addr_lo[0];
        if (legal) mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        legal = (addr_lo == 2'b00);
        if (legal) mask = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a dual-port block RAM: zero-wait-state reads and writes,
// read-after-write forwarding, and a two-cycle ERROR response for illegal transfers.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
  input  logic [31:0]           BRAM_RDATA
);

  logic [3:0]            lane_mask;
  logic                  legal;
  logic                  accept;
  logic                  wr_go;
  logic                  fwd_go;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_mask;
  logic                  wr_pend;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;
  state_t                state;
  logic                  unused_bits;

  ahb_bram_lane_decode u_lane_decode (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .mask    (lane_mask),
    .legal   (legal)
  );

  assign word_idx    = HADDR[ADDR_WIDTH+1:2];
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  always_comb begin
    accept = HSEL & HTRANS[1] & HREADY;
    wr_go  = accept & legal & HWRITE;
    fwd_go = accept & legal & ~HWRITE & wr_pend & (wr_addr == word_idx);
  end

  // Address-phase state only advances when the bus is ready; a stalled data
  // phase keeps BRAM_WE asserted with the same address and data.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_mask  <= '0;
      fwd_mask <= '0;
      fwd_data <= '0;
    end else if (HREADY) begin
      wr_pend  <= wr_go;
      fwd_mask <= fwd_go ? wr_mask : '0;
      if (fwd_go) fwd_data <= HWDATA;
      if (wr_go) begin
        wr_addr <= word_idx;
        wr_mask <= lane_mask;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= ST_OK;
      HREADYOUT <= 1'b1;
      HRESP     <= RESP_OKAY;
    end else begin
      case (state)
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= RESP_ERROR;
        end
        ST_OK, ST_ERR2: begin
          if (accept && !legal) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= RESP_ERROR;
          end else begin
            state     <= ST_OK;
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
          end
        end
        default: begin
          state     <= ST_OK;
          HREADYOUT <= 1'b1;
          HRESP     <= RESP_OKAY;
        end
      endcase
    end
  end

  assign BRAM_ADDRA = wr_addr;
  assign BRAM_WDATA = HWDATA;
  assign BRAM_WE    = wr_pend ? wr_mask : 4'b0000;
  assign BRAM_ADDRB = word_idx;

  // The RAM returns old data when read and written at the same edge.
  always_comb begin
    HRDATA = BRAM_RDATA;
    for (int unsigned i = 0; i < 4; i++) begin
      if (fwd_mask[i]) HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

endmodule

// File: doc/ahb_bram_ctrl.md
# ahb_bram_ctrl

AHB-Lite slave that fronts the SoC's dual-port code/data block RAM. It converts processor bus transfers into the RAM's separate write port (address, data, byte enables) and registered read port (one-cycle latency). It runs at zero wait states for legal transfers. Read-after-write forwarding hides the RAM's old-data-on-collision behaviour, and a two-cycle ERROR response is returned for unsupported transfers.

## Interface
- ADDR_WIDTH, 14, RAM word-address width; the RAM word index is HADDR[ADDR_WIDTH+1:2].
- HCLK  in  1  single clock; also drives the RAM.
- HRESETn  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; NONSEQ=2'b10, SEQ=2'b11.
- HSIZE  in  3  transfer size; 0=byte, 1=half, 2=word.
- HWRITE  in  1  1=write.
- HREADY  in  1  bus-wide ready.
- HWDATA  in  32  write data, valid in data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data, valid in data phase.
- BRAM_ADDRA  out  ADDR_WIDTH  RAM write word address.
- BRAM_WDATA  out  32  RAM write data.
- BRAM_WE  out  4  RAM byte write enables; bit i covers bits [8i+7:8i].
- BRAM_ADDRB  out  ADDR_WIDTH  RAM read word address.
- BRAM_RDATA  in  32  RAM read data, one cycle after BRAM_ADDRB.

## Operation
- Accept condition: `accept` = HSEL & HTRANS[1] & HREADY. IDLE and BUSY transfers are ignored.
- Legal transfers:
  - HSIZE=2 with HADDR[1:0]=0.
  - HSIZE=1 with HADDR[0]=0.
  - HSIZE=0 at any address.
- Any other accepted transfer is illegal: HSIZE>=3 or a misaligned half/word.
- Lane decode:
  - byte: lane HADDR[1:0].
  - half: lanes {1,0} if HADDR[1]=0, else {3,2}.
  - word: all four lanes.
- Write, legal: at the accept edge, register the word address into wr_addr and the lane mask into wr_mask, and set wr_pend.
  - During the following data phase: BRAM_ADDRA=wr_addr, BRAM_WDATA=HWDATA (combinational), BRAM_WE=wr_mask when wr_pend=1, otherwise 4'b0000.
  - The RAM commits the write at the edge that ends the data phase (HREADY=1).
- Read, legal: BRAM_ADDRB = HADDR word index at all times (combinational), so BRAM_RDATA is valid in the data phase.
- Forwarding:
  - Condition: a read is accepted while a write data phase is active (wr_pend=1) to the same word.
  - At that edge, capture fwd_mask=wr_mask and fwd_data=HWDATA.
  - In the read data phase, HRDATA byte i = fwd_mask[i] ? fwd_data byte i : BRAM_RDATA byte i.
  - fwd_mask clears at the next accept or idle edge.
- Illegal transfer: no RAM write and no forwarding capture. The FSM steps through the ERROR sequence.
- FSM states:
  - OK: HREADYOUT=1, HRESP=0. An illegal accept moves to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1. Always moves to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Returns to OK, or re-enters ERR1 if another illegal transfer is accepted in this cycle. A legal accept here proceeds normally.
- HRDATA for write or error data phases is don't-care; RTL drives the merged RAM value.

## Timing
- Reset (HRESETn=0 at an HCLK edge):
  - State = OK; HREADYOUT=1, HRESP=0.
  - wr_pend=0, so BRAM_WE=0; wr_addr=0, fwd_mask=0.
  - A write pending when reset is asserted is dropped. The RAM contents themselves are not reset.
- Latency: legal read and write both complete with zero wait states. Read data appears in the cycle after the address phase.
- HREADY=0 (data phase stretched by another slave): registered address-phase state holds. BRAM_WE stays asserted, and rewriting the same data is harmless.
- Back-to-back write then read, same word: the forwarded bytes are returned. Unwritten lanes come from the RAM.
- Back-to-back write then write: wr_* registers are overwritten at the accept edge, and each write is committed in its own data phase.
- Address wrap: HADDR bits above ADDR_WIDTH+1 are ignored, so the RAM aliases.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE codes (BYTE, HALF, WORD).
  - HRESP codes.
  - the FSM state enum (OK, ERR1, ERR2).
- Sub-module ahb_bram_lane_decode (combinational): maps HSIZE and HADDR[1:0] to a 4-bit lane mask and a legal flag.
- Everything else lives in the top module.

## Test plan
- Reset: hold HRESETn=0 for 3 cycles, then release -> HREADYOUT=1, HRESP=0, BRAM_WE=0 on every cycle.
- Word write then read: word write 0xDEADBEEF to 0x40, idle, then word read 0x40 -> BRAM_WE=4'hF with BRAM_ADDRA=0x10 in the write data phase; HRDATA=0xDEADBEEF one cycle after the read address phase.
- Byte and half writes: preload 0x00000000; byte write 0xAB to 0x41; half write 0x1234 to 0x42; word read 0x40 -> BRAM_WE=4'b0010 then 4'b1100; HRDATA=0x1234AB00.
- Forwarding: preload 0x11223344 at 0x80; byte write 0x99 to 0x80 immediately followed by word read 0x80 -> HRDATA=0x11223399.
- Illegal transfers: HSIZE=3 write to 0x0 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), BRAM_WE=0 throughout. Misaligned half read at 0x3 -> same two-cycle ERROR response.
- Stall: another slave holds HREADY=0 for 2 cycles during a write data phase -> wr_addr/wr_mask unchanged; BRAM_WE asserted each cycle; the final RAM word is correct.
